// File: rtl/cc_frogger_pkg.sv
// Shared Frogger definitions: controller state encoding and row-7 defaults.
package cc_frogger_pkg;

   localparam int         DATAWIDTH_DEF = 8;
   localparam logic [7:0] WIN_MASK_DEF  = 8'hFF;
   localparam logic [3:0] COUNT_MAX     = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COMMIT   = 3'd1,
      ST_HOLD     = 3'd2,
      ST_LEVELUP  = 3'd3,
      ST_CLEARROW = 3'd4
   } state_t;

endpackage

// File: rtl/cc_nestcommit_holdcnt.sv
// Loadable down-counter with a done flag; shared by the nest and respawn controllers.
module cc_nestcommit_holdcnt #(
   parameter int W = 24
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         en_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else if (clr_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cc_nestcommit.sv
// Row-7 nest write-back controller: commits filled nests, requests respawn,
// and signals level completion before wiping the home row.
module cc_nestcommit
   import cc_frogger_pkg::*;
#(
   parameter int                   DATAWIDTH   = DATAWIDTH_DEF,
   parameter logic [DATAWIDTH-1:0] WIN_MASK    = DATAWIDTH'(WIN_MASK_DEF),
   parameter int                   HOLD_CYCLES = 4,
   parameter int                   HOLD_W      = 24
) (
   input  logic                 CC_NESTCOMMIT_CLOCK_50,
   input  logic                 CC_NESTCOMMIT_RESET_InLow,
   input  logic                 CC_NESTCOMMIT_Clear_InHigh,
   input  logic                 CC_NESTCOMMIT_NN_InLow,
   input  logic                 CC_NESTCOMMIT_Lose_InLow,
   input  logic [DATAWIDTH-1:0] CC_NESTCOMMIT_WinF_In,
   output logic [DATAWIDTH-1:0] CC_NESTCOMMIT_Row7_Out,
   output logic                 CC_NESTCOMMIT_Load_OutHigh,
   output logic                 CC_NESTCOMMIT_Respawn_OutHigh,
   output logic                 CC_NESTCOMMIT_LevelUp_OutHigh,
   output logic [3:0]           CC_NESTCOMMIT_Count_Out,
   output logic                 CC_NESTCOMMIT_Busy_OutHigh
);

   // The counter is preloaded with HOLD_CYCLES-1 so HOLD lasts exactly HOLD_CYCLES edges.
   localparam int HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

   state_t               state_q;
   logic [DATAWIDTH-1:0] shadow_q, lat_q;
   logic [3:0]           count_q;
   logic                 nn_q, first_q;
   logic                 load_q, resp_q, lvl_q, busy_q;

   logic nest_evt, same_row, hold_load, hold_en, hold_done, row_full;

   assign nest_evt  = CC_NESTCOMMIT_NN_InLow && !nn_q && !CC_NESTCOMMIT_Lose_InLow;
   assign same_row  = (CC_NESTCOMMIT_WinF_In == shadow_q);
   assign hold_load = (state_q == ST_COMMIT) || ((state_q == ST_IDLE) && nest_evt && same_row);
   assign hold_en   = (state_q == ST_HOLD);
   assign row_full  = ((shadow_q & WIN_MASK) == WIN_MASK);

   cc_nestcommit_holdcnt #(.W(HOLD_W)) u_holdcnt (
      .clk_i  (CC_NESTCOMMIT_CLOCK_50),
      .rst_ni (CC_NESTCOMMIT_RESET_InLow),
      .clr_i  (CC_NESTCOMMIT_Clear_InHigh),
      .load_i (hold_load),
      .val_i  (HOLD_W'(HOLD_INIT)),
      .en_i   (hold_en),
      .done_o (hold_done)
   );

   always_ff @(posedge CC_NESTCOMMIT_CLOCK_50 or negedge CC_NESTCOMMIT_RESET_InLow) begin
      if (!CC_NESTCOMMIT_RESET_InLow) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         lat_q    <= '0;
         count_q  <= '0;
         nn_q     <= 1'b0;
         first_q  <= 1'b0;
         load_q   <= 1'b0;
         resp_q   <= 1'b0;
         lvl_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else if (CC_NESTCOMMIT_Clear_InHigh) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         lat_q    <= '0;
         count_q  <= '0;
         nn_q     <= 1'b0;
         first_q  <= 1'b0;
         load_q   <= 1'b0;
         resp_q   <= 1'b0;
         lvl_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         nn_q   <= CC_NESTCOMMIT_NN_InLow;
         load_q <= 1'b0;
         resp_q <= 1'b0;
         lvl_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (nest_evt) begin
                  busy_q <= 1'b1;
                  if (!same_row) begin
                     lat_q   <= CC_NESTCOMMIT_WinF_In;
                     state_q <= ST_COMMIT;
                  end else begin
                     first_q <= 1'b1;
                     state_q <= ST_HOLD;
                  end
               end
            end
            ST_COMMIT: begin
               load_q   <= 1'b1;
               shadow_q <= lat_q;
               if (count_q != COUNT_MAX)
                  count_q <= count_q + 4'd1;
               first_q  <= 1'b1;
               state_q  <= ST_HOLD;
            end
            // Nest edges are deliberately ignored here: the frog still sits on row 7.
            ST_HOLD: begin
               resp_q  <= first_q;
               first_q <= 1'b0;
               if (hold_done) begin
                  state_q <= row_full ? ST_LEVELUP : ST_IDLE;
                  busy_q  <= row_full;
               end
            end
            ST_LEVELUP: begin
               lvl_q   <= 1'b1;
               state_q <= ST_CLEARROW;
            end
            ST_CLEARROW: begin
               load_q   <= 1'b1;
               shadow_q <= '0;
               count_q  <= '0;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign CC_NESTCOMMIT_Row7_Out        = shadow_q;
   assign CC_NESTCOMMIT_Load_OutHigh    = load_q;
   assign CC_NESTCOMMIT_Respawn_OutHigh = resp_q;
   assign CC_NESTCOMMIT_LevelUp_OutHigh = lvl_q;
   assign CC_NESTCOMMIT_Count_Out       = count_q;
   assign CC_NESTCOMMIT_Busy_OutHigh    = busy_q;

endmodule

// File: tb/tb_cc_nestcommit.sv
// Scoreboard bench for cc_nestcommit: directed nest sequences with hand-timed expected events.
module tb_cc_nestcommit;

   localparam int H      = 4;
   localparam int K_LOAD = 0;
   localparam int K_RESP = 1;
   localparam int K_LVL  = 2;

   logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, nn = 1'b0, lose = 1'b0;
   logic [7:0] winf = 8'h00;
   logic [7:0] row;
   logic [3:0] cnt;
   logic       load, resp, lvl, busy;

   int checks = 0, errors = 0, cyc = 0;

   typedef struct {
      int         kind;
      int         at;
      logic [7:0] row;
      logic [3:0] cnt;
   } exp_t;
   exp_t q[$];

   cc_nestcommit #(
      .DATAWIDTH(8), .WIN_MASK(8'h0F), .HOLD_CYCLES(H), .HOLD_W(24)
   ) dut (
      .CC_NESTCOMMIT_CLOCK_50        (clk),
      .CC_NESTCOMMIT_RESET_InLow     (rst_n),
      .CC_NESTCOMMIT_Clear_InHigh    (clr),
      .CC_NESTCOMMIT_NN_InLow        (nn),
      .CC_NESTCOMMIT_Lose_InLow      (lose),
      .CC_NESTCOMMIT_WinF_In         (winf),
      .CC_NESTCOMMIT_Row7_Out        (row),
      .CC_NESTCOMMIT_Load_OutHigh    (load),
      .CC_NESTCOMMIT_Respawn_OutHigh (resp),
      .CC_NESTCOMMIT_LevelUp_OutHigh (lvl),
      .CC_NESTCOMMIT_Count_Out       (cnt),
      .CC_NESTCOMMIT_Busy_OutHigh    (busy)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int at, input logic [7:0] r, input logic [3:0] c);
      exp_t e;
      e.kind = kind; e.at = at; e.row = r; e.cnt = c;
      q.push_back(e);
   endtask

   task automatic mon(input int kind, input string name);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected pulse at cycle %0d row=%0h cnt=%0d", name, cyc, row, cnt);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.at != cyc ||
             (kind == K_LOAD && (row !== e.row || cnt !== e.cnt))) begin
            errors++;
            $display("FAIL %s actual kind=%0d cyc=%0d row=%0h cnt=%0d required kind=%0d cyc=%0d row=%0h cnt=%0d",
                     name, kind, cyc, row, cnt, e.kind, e.at, e.row, e.cnt);
         end
      end
   endtask

   always @(negedge clk) begin
      if (load) mon(K_LOAD, "load");
      if (resp) mon(K_RESP, "respawn");
      if (lvl)  mon(K_LVL,  "levelup");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic nest(input logic [7:0] w, input logic ls);
      winf = w; lose = ls; nn = 1'b1;
      step(1);
      nn = 1'b0; lose = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 50) begin
         step(1);
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s busy timeout actual=1 required=0", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [7:0] ws [4];
      ws[0] = 8'h01; ws[1] = 8'h03; ws[2] = 8'h07; ws[3] = 8'h0F;

      #1;
      chk("reset_state", {20'h0, row, load, resp, lvl, cnt, busy}, 32'h0);
      step(2);
      rst_n = 1'b1;
      step(1);

      // async reset in the middle of HOLD
      c = cyc;
      push(K_LOAD, c + 2, 8'h05, 4'd1);
      push(K_RESP, c + 3, 8'h00, 4'd0);
      nest(8'h05, 1'b0);
      step(4);
      chk("t1_busy_in_hold", {31'h0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_row", {24'h0, row}, 32'h0);
      chk("t1_async_ctl", {27'h0, load, resp, lvl, busy, 1'b0}, 32'h0);
      chk("t1_async_cnt", {28'h0, cnt}, 32'h0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("t1_idle_after", {27'h0, busy, cnt}, 32'h0);

      // single commit timing
      c = cyc;
      push(K_LOAD, c + 2, 8'h01, 4'd1);
      push(K_RESP, c + 3, 8'h00, 4'd0);
      nest(8'h01, 1'b0);
      step(H);
      chk("t2_busy_last_hold", {31'h0, busy}, 32'h1);
      step(1);
      chk("t2_busy_low", {31'h0, busy}, 32'h0);
      chk("t2_count", {28'h0, cnt}, 32'h1);
      chk("t2_row", {24'h0, row}, 32'h01);

      // already-filled column
      c = cyc;
      push(K_RESP, c + 2, 8'h00, 4'd0);
      nest(8'h01, 1'b0);
      chk("t3_busy_hold", {31'h0, busy}, 32'h1);
      wait_idle("t3");
      chk("t3_count", {28'h0, cnt}, 32'h1);
      chk("t3_row", {24'h0, row}, 32'h01);

      // lose wins over a simultaneous nest edge
      nest(8'h02, 1'b1);
      chk("t4_busy", {31'h0, busy}, 32'h0);
      step(3);
      chk("t4_row", {24'h0, row}, 32'h01);
      chk("t4_count", {28'h0, cnt}, 32'h1);

      // clear, then fill mask 0F to level up
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("t5_cleared", {23'h0, row, busy}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         c = cyc;
         push(K_LOAD, c + 2, ws[i], 4'(i + 1));
         push(K_RESP, c + 3, 8'h00, 4'd0);
         if (i == 3) begin
            push(K_LVL,  c + 3 + H, 8'h00, 4'd0);
            push(K_LOAD, c + 4 + H, 8'h00, 4'd0);
         end
         nest(ws[i], 1'b0);
         wait_idle("t5_fill");
      end
      chk("t5_count_wiped", {28'h0, cnt}, 32'h0);
      chk("t5_row_wiped", {24'h0, row}, 32'h0);

      // NN held high across HOLD with an extra edge inside HOLD
      c = cyc;
      push(K_LOAD, c + 2, 8'h01, 4'd1);
      push(K_RESP, c + 3, 8'h00, 4'd0);
      winf = 8'h01; nn = 1'b1;
      step(3);
      nn = 1'b0;
      step(1);
      nn = 1'b1;
      step(1);
      wait_idle("t6_hold");
      step(2);
      nn = 1'b0;
      step(1);
      chk("t6_count", {28'h0, cnt}, 32'h1);
      chk("t6_row", {24'h0, row}, 32'h01);

      // clear while in COMMIT
      nest(8'h03, 1'b0);
      chk("t6_in_commit", {31'h0, busy}, 32'h1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("t6_clear_state", {23'h0, row, busy}, 32'h0);
      chk("t6_clear_cnt", {28'h0, cnt}, 32'h0);
      step(3);
      chk("t6_stay_idle", {31'h0, busy}, 32'h0);

      step(2);
      chk("scoreboard_drained", q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cc_nestcommit.md
Name: cc_nestcommit

Overview:
Write-back controller for the home row (row 7) of the Frogger playfield. It consumes the nest detector's nest flag and candidate row-7 value, then commits newly filled nests into the background register row 7. It also requests a frog respawn after every nest and raises a level-complete event when all required nests are filled. It sits between the nest comparator and the background register bank, on the same 50 MHz game clock.

Parameters:
DATAWIDTH, 8, row width in columns.
WIN_MASK, 8'hFF, columns that must be filled for level complete.
HOLD_CYCLES, 4, cycles spent in HOLD after a nest (respawn settle; set large on board).
HOLD_W, 24, width of the hold counter; must be at least clog2(HOLD_CYCLES+1).

Ports:
CC_NESTCOMMIT_CLOCK_50  in  1  system clock; all state updates on rising edge.
CC_NESTCOMMIT_RESET_InLow  in  1  asynchronous, active-low reset.
CC_NESTCOMMIT_Clear_InHigh  in  1  synchronous game-restart clear.
CC_NESTCOMMIT_NN_InLow  in  1  nest flag from comparator (level).
CC_NESTCOMMIT_Lose_InLow  in  1  lose flag; 1 = frog lost this cycle.
CC_NESTCOMMIT_WinF_In  in  DATAWIDTH  candidate row 7 (old row OR frog position).
CC_NESTCOMMIT_Row7_Out  out  DATAWIDTH  row-7 write data to background register.
CC_NESTCOMMIT_Load_OutHigh  out  1  one-cycle write strobe for row 7.
CC_NESTCOMMIT_Respawn_OutHigh  out  1  one-cycle frog respawn request.
CC_NESTCOMMIT_LevelUp_OutHigh  out  1  one-cycle level-complete pulse.
CC_NESTCOMMIT_Count_Out  out  4  number of nests filled this level.
CC_NESTCOMMIT_Busy_OutHigh  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; shadow row = 0; Row7_Out = 0; Count_Out = 0; hold counter = 0.
  - all pulse outputs and Busy = 0; edge-detect register = 0.
- Clear_InHigh (synchronous): same effect as reset on the next edge. Highest priority over every state.
- Nest event = NN_InLow rising edge (NN_InLow=1 and the registered previous value = 0) with Lose_InLow=0. The edge register updates every cycle in every state.
- If nest edge and Lose_InLow=1 occur in the same cycle, lose wins: no event, state unchanged.
- IDLE:
  - On a nest event with WinF_In different from the shadow row, go to COMMIT and latch WinF_In.
  - On a nest event with WinF_In equal to the shadow row (column already filled), go directly to HOLD. Nothing is loaded and Count is unchanged.
- COMMIT (1 cycle):
  - Load_OutHigh=1; Row7_Out = latched value; shadow row = latched value.
  - Count increments; it saturates at 15.
  - Next state is HOLD.
- HOLD:
  - Respawn_OutHigh=1 in the first cycle only.
  - Hold counter runs HOLD_CYCLES cycles.
  - Nest edges in this state are ignored, because the frog is still on row 7.
  - When the count expires: if (shadow & WIN_MASK) == WIN_MASK go to LEVELUP, else go to IDLE.
- LEVELUP (1 cycle): LevelUp_OutHigh=1; next state is CLEARROW.
- CLEARROW (1 cycle):
  - Load_OutHigh=1 with Row7_Out = 0; shadow = 0; Count = 0.
  - Next state is IDLE.
- Latency:
  - nest edge to Load = 2 cycles (edge register, then COMMIT).
  - Respawn follows Load by 1 cycle.
  - LevelUp follows Respawn by HOLD_CYCLES cycles.
- Row7_Out holds its last written value between loads. Outputs are registered, with no combinational path from inputs to outputs.
- Busy_OutHigh = (state != IDLE).
- Reset asserted in any state returns to the reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package cc_frogger_pkg holds:
  - the state encoding constants (IDLE, COMMIT, HOLD, LEVELUP, CLEARROW, 3 bits);
  - the DATAWIDTH default;
  - the WIN_MASK default.
- One natural sub-module, cc_nestcommit_holdcnt:
  - a loadable down-counter with a done flag, used for HOLD;
  - it is reusable by the death/respawn controller.

Test Plan:
1. Reset with RESET_InLow=0 mid-HOLD, HOLD_CYCLES=4 -> all outputs 0 asynchronously; after release, state IDLE and Count=0.
2. WinF_In=8'h01, NN 0->1, Lose=0 -> Load=1 with Row7_Out=8'h01 two cycles later; Respawn one cycle after that; Count=1; Busy low after 4 hold cycles.
3. Shadow=8'h01, NN edge with WinF_In=8'h01 -> no Load, Count stays 1, Respawn=1, HOLD entered.
4. NN edge with Lose=1 in the same cycle, WinF_In=8'h02 -> no Load, no Respawn, Row7_Out stays 8'h01.
5. Fill WIN_MASK=8'h0F via nests with WinF_In 8'h01, 8'h03, 8'h07, 8'h0F -> after the fourth HOLD, LevelUp pulses once; the next cycle gives Load with Row7_Out=8'h00 and Count=0.
6. NN held high across HOLD, plus a second edge during HOLD -> exactly one commit; Clear_InHigh asserted in COMMIT -> next cycle IDLE, Row7_Out=0.
